// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter
// Owns the write side of a bank of 2**AW load-enabled registers.
// After reset it walks the bank once and clears every register. It then
// shares the single write bus between requesters A and B. Arbitration is
// round-robin, and each grant is acknowledged with a one-cycle pulse.
// Every output comes straight from a flop.
module reg_bank_write_arbiter #(
  parameter int DW = 4,
  parameter int AW = 2,
  localparam int N_REG = 2 ** AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [DW-1:0]    data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [DW-1:0]    data_b,
  output logic             ack_b,
  output logic [N_REG-1:0] load,
  output logic [DW-1:0]    bus_in,
  output logic             init_done,
  output logic             last_grant
);

  // Controller states. WRITE is the single cycle in which load/ack are high.
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // The init counter runs one past the last register. That extra count
  // is the cycle that drops load and raises init_done.
  localparam logic [AW:0] INIT_END = (AW + 1)'(N_REG);

  logic [1:0]       r_state;
  logic [AW:0]      r_init_cnt;
  logic             r_rr_ptr;      // 0: A wins a tie, 1: B wins a tie
  logic [N_REG-1:0] r_load;
  logic [DW-1:0]    r_bus_in;
  logic             r_ack_a;
  logic             r_ack_b;
  logic             r_init_done;
  logic             r_last_grant;

  logic             w_grant_valid;
  logic             w_grant_b;     // 1 when B is this cycle's winner
  logic [AW-1:0]    w_win_addr;
  logic [DW-1:0]    w_win_data;

  function automatic logic [N_REG-1:0] onehot(input logic [AW-1:0] idx);
    logic [N_REG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pick the winner among the live requests. B wins when it is the only
  // requester, or when both request and the round-robin pointer favours B.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path leaves
    // one unassigned. An unassigned path would infer a latch.
    w_grant_valid = req_a | req_b;
    w_grant_b     = req_b & (~req_a | r_rr_ptr);
    w_win_addr    = addr_a;
    w_win_data    = data_a;
    if (w_grant_b) begin
      w_win_addr = addr_b;
      w_win_data = data_b;
    end
  end

  // Main sequencer: clear walk, then grant / write / idle. Reset is
  // synchronous, so it is sampled inside the clocked block.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments only. Every
    // right-hand side then sees the values from before this edge.
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_rr_ptr     <= 1'b0;
      r_load       <= '0;
      r_bus_in     <= '0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_init_done  <= 1'b0;
      r_last_grant <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          // Requests are not looked at until the walk is complete.
          r_ack_a <= 1'b0;
          r_ack_b <= 1'b0;
          if (r_init_cnt == INIT_END) begin
            r_load      <= '0;
            r_init_done <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_load     <= onehot(r_init_cnt[AW-1:0]);
            r_bus_in   <= '0;
            r_init_cnt <= r_init_cnt + (AW + 1)'(1);
          end
        end

        ST_IDLE: begin
          if (w_grant_valid) begin
            r_load       <= onehot(w_win_addr);
            r_bus_in     <= w_win_data;
            r_ack_a      <= ~w_grant_b;
            r_ack_b      <= w_grant_b;
            r_last_grant <= w_grant_b;
            // The loser of this grant gets priority on the next tie.
            r_rr_ptr     <= ~w_grant_b;
            r_state      <= ST_WRITE;
          end else begin
            // bus_in keeps its last value while the bus is idle.
            r_load  <= '0;
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
          end
        end

        ST_WRITE: begin
          // The register captures at this edge. A request that is still
          // held is looked at again in the following IDLE cycle.
          r_load  <= '0;
          r_ack_a <= 1'b0;
          r_ack_b <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          // An unreachable encoding restarts the clear walk.
          r_state    <= ST_INIT;
          r_init_cnt <= '0;
          r_load     <= '0;
          r_ack_a    <= 1'b0;
          r_ack_b    <= 1'b0;
        end
      endcase
    end
  end

  assign load       = r_load;
  assign bus_in     = r_bus_in;
  assign ack_a      = r_ack_a;
  assign ack_b      = r_ack_b;
  assign init_done  = r_init_done;
  assign last_grant = r_last_grant;

endmodule
